// File: rtl/setup_latch_bank.sv
// setup_latch_bank: double-buffered game-setup settings latch.
// Writes land in shadows; commit copies all of them to the active set at once.
module setup_latch_bank #(
    parameter int DATA_SIZE = 5,
    parameter int CHANNELS  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           wr_en,
    input  logic [CHANNELS*DATA_SIZE-1:0] wr_data,
    input  logic                          commit,
    input  logic                          discard,
    input  logic                          lock,
    input  logic                          unlock,
    output logic [CHANNELS*DATA_SIZE-1:0] data_out,
    output logic [CHANNELS*DATA_SIZE-1:0] shadow_out,
    output logic                          pending,
    output logic                          locked,
    output logic                          commit_done,
    output logic [CHANNELS-1:0]           changed,
    output logic                          wr_drop
);

    localparam int W = CHANNELS * DATA_SIZE;

    typedef enum logic [1:0] {
        ST_OPEN,
        ST_PENDING,
        ST_LOCKED
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]        shadow_q, shadow_d;
    logic [W-1:0]        active_q, active_d;
    logic [CHANNELS-1:0] changed_q, changed_d;
    logic                commit_done_q, commit_done_d;
    logic                wr_drop_q, wr_drop_d;

    logic                any_wr;
    logic                do_commit;
    logic                do_write;
    logic                do_discard;
    logic                drop;
    logic [W-1:0]        wr_mask;
    logic [W-1:0]        merged;
    logic [CHANNELS-1:0] differs;

    assign any_wr = |wr_en;

    // Expand per-channel strobes into a bit mask and compare shadow vs active
    always_comb begin
        wr_mask = '0;
        differs = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_mask[i*DATA_SIZE +: DATA_SIZE] = {DATA_SIZE{wr_en[i]}};
            differs[i] = shadow_q[i*DATA_SIZE +: DATA_SIZE]
                         != active_q[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    assign merged = (shadow_q & ~wr_mask) | (wr_data & wr_mask);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: lock > unlock > commit > discard > write
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OPEN: begin
                if (lock) begin
                    state_d = ST_LOCKED;
                end else if (any_wr) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (lock) begin
                    state_d = ST_LOCKED;
                end else if (commit) begin
                    state_d = any_wr ? ST_PENDING : ST_OPEN;
                end else if (discard) begin
                    state_d = ST_OPEN;
                end
            end
            ST_LOCKED: begin
                if (!lock && unlock) begin
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    // Actions per state; a commit snapshots the shadow before same-cycle writes
    always_comb begin
        do_commit  = 1'b0;
        do_write   = 1'b0;
        do_discard = 1'b0;
        drop       = 1'b0;
        unique case (state_q)
            ST_OPEN: begin
                if (lock) begin
                    drop = any_wr;
                end else begin
                    do_write = any_wr;
                end
            end
            ST_PENDING: begin
                if (lock) begin
                    do_commit = 1'b1;
                    drop      = any_wr;
                end else if (commit) begin
                    do_commit = 1'b1;
                    do_write  = any_wr;
                end else if (discard) begin
                    do_discard = 1'b1;
                    drop       = any_wr;
                end else begin
                    do_write = any_wr;
                end
            end
            ST_LOCKED: begin
                drop = any_wr;
            end
            default: begin
                drop = 1'b0;
            end
        endcase
    end

    // Next values for the datapath and the one-cycle pulses
    always_comb begin
        active_d      = do_commit ? shadow_q : active_q;
        shadow_d      = shadow_q;
        if (do_discard) begin
            shadow_d = active_q;
        end else if (do_write) begin
            shadow_d = merged;
        end
        changed_d     = do_commit ? differs : '0;
        commit_done_d = do_commit;
        wr_drop_d     = drop;
    end

    // Datapath and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q      <= '0;
            active_q      <= '0;
            changed_q     <= '0;
            commit_done_q <= 1'b0;
            wr_drop_q     <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            changed_q     <= changed_d;
            commit_done_q <= commit_done_d;
            wr_drop_q     <= wr_drop_d;
        end
    end

    assign data_out    = active_q;
    assign shadow_out  = shadow_q;
    assign pending     = (state_q == ST_PENDING);
    assign locked      = (state_q == ST_LOCKED);
    assign commit_done = commit_done_q;
    assign changed     = changed_q;
    assign wr_drop     = wr_drop_q;

endmodule

// File: tb/tb_setup_latch_bank.sv
// tb_setup_latch_bank: directed scoreboard bench for setup_latch_bank.
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_setup_latch_bank;

    logic        clk;
    logic        rst;
    logic [3:0]  wr_en;
    logic [19:0] wr_data;
    logic        commit;
    logic        discard;
    logic        lock;
    logic        unlock;
    logic [19:0] data_out;
    logic [19:0] shadow_out;
    logic        pending;
    logic        locked;
    logic        commit_done;
    logic [3:0]  changed;
    logic        wr_drop;

    typedef struct packed {
        logic [19:0] data;
        logic [19:0] shadow;
        logic        pend;
        logic        lck;
        logic        cd;
        logic [3:0]  chg;
        logic        drop;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    setup_latch_bank #(.DATA_SIZE(5), .CHANNELS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .commit     (commit),
        .discard    (discard),
        .lock       (lock),
        .unlock     (unlock),
        .data_out   (data_out),
        .shadow_out (shadow_out),
        .pending    (pending),
        .locked     (locked),
        .commit_done(commit_done),
        .changed    (changed),
        .wr_drop    (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] pk(input logic [4:0] c0, input logic [4:0] c1,
                                       input logic [4:0] c2, input logic [4:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per cycle, sampled on the falling edge
    always begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("data_out", 32'(data_out), 32'(e.data));
            chk("shadow_out", 32'(shadow_out), 32'(e.shadow));
            chk("pending", 32'(pending), 32'(e.pend));
            chk("locked", 32'(locked), 32'(e.lck));
            chk("commit_done", 32'(commit_done), 32'(e.cd));
            chk("changed", 32'(changed), 32'(e.chg));
            chk("wr_drop", 32'(wr_drop), 32'(e.drop));
        end
    end

    task automatic step(input logic r, input logic [3:0] we, input logic [19:0] wd,
                        input logic cm, input logic dc, input logic lk, input logic ul,
                        input logic [19:0] ed, input logic [19:0] es,
                        input logic ep, input logic el, input logic ec,
                        input logic [3:0] eg, input logic edr);
        exp_t e;
        @(negedge clk);
        #1;
        rst     = r;
        wr_en   = we;
        wr_data = wd;
        commit  = cm;
        discard = dc;
        lock    = lk;
        unlock  = ul;
        @(posedge clk);
        #1;
        e.data   = ed;
        e.shadow = es;
        e.pend   = ep;
        e.lck    = el;
        e.cd     = ec;
        e.chg    = eg;
        e.drop   = edr;
        q.push_back(e);
    endtask

    initial begin
        logic [19:0] a, b, c, d;
        rst     = 1'b1;
        wr_en   = '0;
        wr_data = '0;
        commit  = 1'b0;
        discard = 1'b0;
        lock    = 1'b0;
        unlock  = 1'b0;
        a = pk(9, 0, 20, 0);
        b = pk(9, 0, 20, 3);
        c = pk(9, 0, 20, 31);
        d = pk(12, 0, 20, 31);

        // reset held, then idle
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // write ch0/ch2, commit, pulse clears
        step(0, 4'b0101, a, 0, 0, 0, 0, 0, a, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, a, a, 0, 0, 1, 4'b0101, 0);
        step(0, 0, 0, 0, 0, 0, 0, a, a, 0, 0, 0, 0, 0);

        // write ch1 then discard
        step(0, 4'b0010, pk(0, 7, 0, 0), 0, 0, 0, 0, a, pk(9, 7, 20, 0), 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, a, a, 0, 0, 0, 0, 0);

        // commit in OPEN is ignored
        step(0, 0, 0, 1, 0, 0, 0, a, a, 0, 0, 0, 0, 0);

        // commit together with a write
        step(0, 4'b1000, pk(0, 0, 0, 3), 0, 0, 0, 0, a, b, 1, 0, 0, 0, 0);
        step(0, 4'b1000, pk(0, 0, 0, 31), 1, 0, 0, 0, b, c, 1, 0, 1, 4'b1000, 0);
        step(0, 0, 0, 0, 0, 0, 0, b, c, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, c, c, 0, 0, 1, 4'b1000, 0);

        // commit with shadow equal to active
        step(0, 4'b0001, pk(9, 0, 0, 0), 0, 0, 0, 0, c, c, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, c, c, 0, 0, 1, 0, 0);

        // lock while pending with a write to ch1
        step(0, 4'b0001, pk(12, 0, 0, 0), 0, 0, 0, 0, c, d, 1, 0, 0, 0, 0);
        step(0, 4'b0010, pk(0, 5, 0, 0), 0, 0, 1, 0, d, d, 0, 1, 1, 4'b0001, 1);
        step(0, 4'b1111, pk(1, 2, 3, 4), 0, 0, 0, 0, d, d, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0, d, d, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, d, d, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, d, d, 0, 0, 0, 0, 0);

        // multi-channel write, then discard with a dropped write
        step(0, 4'b1111, pk(1, 2, 3, 4), 0, 0, 0, 0, d, pk(1, 2, 3, 4), 1, 0, 0, 0, 0);
        step(0, 4'b0001, pk(7, 0, 0, 0), 0, 1, 0, 0, d, d, 0, 0, 0, 0, 1);

        // reset asserted on the commit cycle
        step(0, 4'b0100, pk(0, 0, 5, 0), 0, 0, 0, 0, d, pk(12, 0, 5, 31), 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/setup_latch_bank.md
Name: setup_latch_bank

Overview:
- Multi-channel, double-buffered settings latch for the game-setup path (board size, mine count, difficulty and similar fields).
- Per-channel writes go into shadow registers. A commit atomically transfers all shadows to the active outputs. Discard reverts the shadows.
- Lock freezes the active settings for the duration of a game.
- Downstream game logic only ever sees a consistent set of committed values.

Parameters:
- DATA_SIZE, 5, width of each channel in bits
- CHANNELS, 4, number of independent setting channels (1..16)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  CHANNELS  per-channel shadow write strobe
- wr_data  in  CHANNELS*DATA_SIZE  packed write data; channel i at bits [i*DATA_SIZE +: DATA_SIZE]
- commit  in  1  request to copy all shadows to active (level sampled each cycle)
- discard  in  1  request to reload shadows from active
- lock  in  1  freeze request (game start)
- unlock  in  1  release request (game over)
- data_out  out  CHANNELS*DATA_SIZE  packed active (committed) values
- shadow_out  out  CHANNELS*DATA_SIZE  packed shadow values, for on-screen preview
- pending  out  1  high while state = PENDING
- locked  out  1  high while state = LOCKED
- commit_done  out  1  one-cycle pulse, coincident with data_out update
- changed  out  CHANNELS  one-cycle mask, coincident with commit_done; bit i = new active value differs from old
- wr_drop  out  1  one-cycle pulse when a write strobe is ignored

Behaviour:
- Reset (async, rst=1): shadows, actives, changed, commit_done, wr_drop all 0; state = OPEN; pending = 0; locked = 0. Reset mid-commit or mid-lock abandons the operation; no pulse is emitted after reset release.
- All outputs are registered. data_out, commit_done and changed update on the clock edge that samples commit, i.e. they are visible 1 cycle after commit is asserted.
- FSM states: OPEN, PENDING, LOCKED. Evaluation priority per cycle: lock > unlock > commit > discard > write.
- OPEN:
  - Any wr_en bit set: the shadows for the set channels load wr_data → PENDING.
  - lock → LOCKED.
  - commit, discard and unlock are ignored; no pulse is produced.
- PENDING:
  - lock: perform a commit (data_out <= shadow, commit_done and changed pulse) → LOCKED. Writes in the same cycle are dropped, and wr_drop pulses.
  - commit: active <= shadow value as it stood before this edge; commit_done pulses; changed = per-channel old≠new.
    - If no wr_en is set in the same cycle → OPEN.
    - If any wr_en is set in the same cycle, the write lands in the shadow after the snapshot, the state stays PENDING, and that write is not in the committed set.
  - discard (without commit): shadow <= active → OPEN. Writes in the same cycle are dropped, and wr_drop pulses.
  - A write alone updates the shadow and the state stays PENDING.
  - A commit whose shadow equals active still pulses commit_done, with changed = 0.
- LOCKED:
  - data_out and shadows are frozen.
  - Any wr_en → wr_drop pulse; no register changes.
  - commit and discard are ignored.
  - unlock → OPEN (the shadow already equals active).
  - lock and unlock in the same cycle: lock wins, so the state stays LOCKED.
- A write to multiple channels in one cycle is allowed; all set channels update together.
- Each of the pulses (commit_done, changed, wr_drop) is high for exactly one cycle and is 0 otherwise.
- Widths: no arithmetic; comparisons for changed are full DATA_SIZE equality per channel.

Test Plan:
- Reset then idle: with DATA_SIZE=5, CHANNELS=4, hold rst, then release → data_out=0, shadow_out=0, pending=0, locked=0, no pulses for 10 cycles.
- Write then commit:
  - wr_en=4'b0101 with ch0=5'd9, ch2=5'd20 → pending=1, shadow_out shows 9 and 20, data_out still 0.
  - commit for 1 cycle → next cycle data_out ch0=9, ch2=20; commit_done=1; changed=4'b0101; pending=0.
- Discard: after the commit above, write ch1=5'd7, then discard → shadow ch1 back to 0, data_out unchanged, pending=0, commit_done never asserted.
- Simultaneous commit and write:
  - In PENDING with shadow ch3=5'd3, assert commit together with wr_en ch3=5'd31 → data_out ch3=3, changed bit3=1.
  - Following cycle: shadow ch3=31, pending=1.
- Lock while PENDING:
  - Shadow ch0=5'd12 pending; assert lock with wr_en ch1 → data_out ch0=12, commit_done=1, locked=1, wr_drop=1, ch1 unchanged.
  - Further writes → wr_drop pulses, outputs frozen.
  - unlock → OPEN, locked=0.
- Reset mid-operation: assert rst on the cycle commit is high → after release data_out=0, commit_done never pulses, state OPEN.
